// File: rtl/dsp_sequential_inverse.sv
// Multi-cycle inverse of the combinational DSP multiply/divide primitive.
// The unit performs restoring division (m=1) or shift-add multiplication (m=0) behind a valid/ready handshake.
module dsp_sequential_inverse #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   x,
  input  logic [DATA_WIDTH/2-1:0] b,
  input  logic                    m,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   q,
  output logic [DATA_WIDTH/2-1:0] r,
  output logic                    dz
);

  localparam int HW = DATA_WIDTH / 2;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [DATA_WIDTH-1:0] r_x;
  logic [HW-1:0]         r_b;
  logic                  r_m;
  logic [HW-1:0]         r_part;
  logic [DATA_WIDTH-1:0] r_quo;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_q;
  logic [HW-1:0]         r_r;
  logic                  r_dz;

  logic                  w_accept;
  logic                  w_div0;
  logic                  w_last;
  logic [HW:0]           w_shifted;
  logic                  w_ge;
  logic [HW-1:0]         w_part_nxt;
  logic [DATA_WIDTH-1:0] w_quo_nxt;
  logic [DATA_WIDTH-1:0] w_addend;
  logic [DATA_WIDTH-1:0] w_acc_nxt;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign q         = r_q;
  assign r         = r_r;
  assign dz        = r_dz;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_div0   = m && (b == '0);
  assign w_last   = (r_cnt == (r_m ? CW'(DATA_WIDTH - 1) : CW'(HW - 1)));

  // Restoring step: the previous partial remainder is below the divisor, so it fits in HW bits.
  // The shifted partial remainder needs HW+1 bits.
  assign w_shifted  = {r_part, r_x[DATA_WIDTH-1]};
  assign w_ge       = (w_shifted >= {1'b0, r_b});
  assign w_part_nxt = HW'(w_ge ? (w_shifted - {1'b0, r_b}) : w_shifted);
  assign w_quo_nxt  = {r_quo[DATA_WIDTH-2:0], w_ge};

  // Shift-add step: r_b shifts right, so bit 0 is always the current multiplier bit.
  assign w_addend  = {{HW{1'b0}}, r_x[HW-1:0]} << r_cnt;
  assign w_acc_nxt = r_acc + (r_b[0] ? w_addend : '0);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: default first so no path leaves w_next_state unassigned (no latch).
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = w_div0 ? DONE : BUSY;
      BUSY:    if (w_last) w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x    <= '0;
      r_b    <= '0;
      r_m    <= 1'b0;
      r_part <= '0;
      r_quo  <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_q    <= '0;
      r_r    <= '0;
      r_dz   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_x    <= x;
            r_b    <= b;
            r_m    <= m;
            r_part <= '0;
            r_quo  <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            if (w_div0) begin
              r_q  <= '1;
              r_r  <= '0;
              r_dz <= 1'b1;
            end
          end
        end
        BUSY: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_m) begin
            r_part <= w_part_nxt;
            r_quo  <= w_quo_nxt;
            r_x    <= {r_x[DATA_WIDTH-2:0], 1'b0};
          end else begin
            r_acc <= w_acc_nxt;
            r_b   <= r_b >> 1;
          end
          if (w_last) begin
            r_cnt <= '0;
            r_q   <= r_m ? w_quo_nxt : w_acc_nxt;
            r_r   <= r_m ? w_part_nxt : '0;
            r_dz  <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_q  <= '0;
            r_r  <= '0;
            r_dz <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_sequential_inverse.sv
// Self-checking bench for dsp_sequential_inverse.
// It combines an arithmetic reference model that is compared every cycle with directed literal checks.
module tb_dsp_sequential_inverse;
  localparam int DW = 4;
  localparam int HW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] x = '0;
  logic [HW-1:0] b = '0;
  logic          m = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] q;
  logic [HW-1:0] r;
  logic          dz;

  always #5 clk = ~clk;

  dsp_sequential_inverse #(.DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .b        (b),
    .m        (m),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .q        (q),
    .r        (r),
    .dz       (dz)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: 0 idle, 1 computing, 2 result presented.
  int mdl_phase = 0;
  int mdl_left  = 0;
  int pend_q    = 0;
  int pend_r    = 0;
  int pend_dz   = 0;

  always @(posedge clk) begin
    if (rst) begin
      mdl_phase = 0;
    end else begin
      case (mdl_phase)
        0: if (in_valid) begin
          if (m && b == 0) begin
            pend_q = (1 << DW) - 1; pend_r = 0; pend_dz = 1; mdl_phase = 2;
          end else if (m) begin
            pend_q = int'(x) / int'(b); pend_r = int'(x) % int'(b); pend_dz = 0;
            mdl_left = DW; mdl_phase = 1;
          end else begin
            pend_q = int'(x[HW-1:0]) * int'(b); pend_r = 0; pend_dz = 0;
            mdl_left = HW; mdl_phase = 1;
          end
        end
        1: begin
          mdl_left--;
          if (mdl_left == 0) mdl_phase = 2;
        end
        default: if (out_ready) mdl_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model in_ready", in_ready, mdl_phase == 0);
      check("model out_valid", out_valid, mdl_phase == 2);
      check("model q", q, (mdl_phase == 2) ? pend_q : 0);
      check("model r", r, (mdl_phase == 2) ? pend_r : 0);
      check("model dz", dz, (mdl_phase == 2) ? pend_dz : 0);
    end
  end

  // Issue one request, scramble the inputs after accept, and measure edges from accept to out_valid.
  task automatic run_op(input string name, input bit mm, input int xx, input int bb,
                        input int eq, input int er, input int edz, input int elat);
    int lat;
    @(negedge clk);
    m = mm; x = DW'(xx); b = HW'(bb); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; x = ~x; b = ~b; m = ~m;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, lat, elat);
    check({name, " q"}, q, eq);
    check({name, " r"}, r, er);
    check({name, " dz"}, dz, edz);
    if (out_ready) begin
      @(negedge clk);
      check({name, " in_ready after retire"}, in_ready, 1);
      check({name, " out_valid after retire"}, out_valid, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset q", q, 0);
    check("reset r", r, 0);
    check("reset dz", dz, 0);
    rst = 1'b0;

    run_op("div13_3", 1'b1, 13, 3, 4, 1, 0, 4);
    run_op("div7_0", 1'b1, 7, 0, 15, 0, 1, 0);
    run_op("div15_1", 1'b1, 15, 1, 15, 0, 0, 4);
    run_op("mul3_3", 1'b0, 3, 3, 9, 0, 0, 2);
    run_op("mul14_3", 1'b0, 14, 3, 6, 0, 0, 2);

    // Backpressure: hold DONE for five cycles while new requests knock.
    out_ready = 1'b0;
    @(negedge clk);
    m = 1'b0; x = 4'd2; b = 2'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp latency", lat, 2);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; m = 1'b1; x = DW'($urandom); b = HW'($urandom);
      @(negedge clk);
      check("bp out_valid", out_valid, 1);
      check("bp in_ready", in_ready, 0);
      check("bp q", q, 6);
      check("bp r", r, 0);
      check("bp dz", dz, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp retire out_valid", out_valid, 0);
    check("bp retire in_ready", in_ready, 1);

    // Reset after the second BUSY edge of a divide.
    @(negedge clk);
    m = 1'b1; x = 4'd13; b = 2'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst in_ready", in_ready, 1);
    check("midrst out_valid", out_valid, 0);
    check("midrst q", q, 0);
    check("midrst r", r, 0);
    check("midrst dz", dz, 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midrst no out_valid", out_valid, 0);
    end
    run_op("div6_2", 1'b1, 6, 2, 3, 0, 0, 4);

    // Exhaustive divide against plain arithmetic.
    for (int xx = 0; xx < 16; xx++) begin
      for (int bb = 0; bb < 4; bb++) begin
        if (bb == 0) run_op("exh div0", 1'b1, xx, bb, 15, 0, 1, 0);
        else         run_op("exh div", 1'b1, xx, bb, xx / bb, xx % bb, 0, 4);
      end
    end

    // Exhaustive multiply with round-trip through divide; upper multiplicand bits are junk.
    for (int a = 0; a < 4; a++) begin
      for (int bb = 0; bb < 4; bb++) begin
        run_op("exh mul", 1'b0, a + 4 * ((a + bb) % 4), bb, a * bb, 0, 0, 2);
        if (bb != 0) run_op("roundtrip div", 1'b1, a * bb, bb, a, 0, 0, 4);
      end
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
